suma_carga_multi: RTL and testbench



---
 rtl/suma_carga_pkg.sv | 22 ++
 rtl/suma_carga_multi_sumador_ripple_n.sv | 27 ++
 rtl/suma_carga_multi.sv | 158 +++++++++++++++
 tb/tb_suma_carga_multi.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/suma_carga_pkg.sv
// Shared definitions for the multi-battery charge adder.
//   estado_t      : FSM state encoding (IDLE, ACUM, DONE)
//   f_ancho_total : width of the total charge, wide enough for N_BAT full-scale readings
//   f_ancho_cnt   : width of the low-battery counter (holds 0..N_BAT)
package suma_carga_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACUM = 2'd1,
        DONE = 2'd2
    } estado_t;

    function automatic int unsigned f_ancho_total(input int unsigned n_bat,
                                                  input int unsigned ancho);
        return ancho + $clog2(n_bat);
    endfunction

    function automatic int unsigned f_ancho_cnt(input int unsigned n_bat);
        return $clog2(n_bat + 1);
    endfunction

endpackage

// File: rtl/suma_carga_multi_sumador_ripple_n.sv
// Ripple-carry adder built from a chain of 1-bit full adders, carry-in tied to 0.
//   i_a, i_b : operands (ANCHO bits)
//   o_suma   : sum (ANCHO bits)
//   o_cout   : carry out of the top full adder
module sumador_ripple_n #(
    parameter int unsigned ANCHO = 4
) (
    input  logic [ANCHO-1:0] i_a,
    input  logic [ANCHO-1:0] i_b,
    output logic [ANCHO-1:0] o_suma,
    output logic             o_cout
);

    logic w_carry;

    // Carry ripples from bit 0 upward through one full adder per bit
    always_comb begin
        w_carry = 1'b0;
        o_suma  = '0;
        for (int i = 0; i < int'(ANCHO); i++) begin
            o_suma[i] = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry   = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_carry;
    end

endmodule

// File: rtl/suma_carga_multi.sv
// Sequential N_BAT-battery charge adder with valid/ready handshakes.
// Accepts a packed vector of readings, accumulates one battery per clock
// through a single ripple adder, and returns the total (optionally clamped
// to LIMITE), a clamp flag and the number of batteries below UMBRAL.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : input handshake, cargas sampled on acceptance
//   cargas                : battery i at bits [i*ANCHO +: ANCHO]
//   out_valid / out_ready : result handshake, results held while stalled
//   carga_total, saturado, bajas : registered results
module suma_carga_multi
    import suma_carga_pkg::*;
#(
    parameter  int unsigned N_BAT       = 4,
    parameter  int unsigned ANCHO       = 4,
    parameter  int unsigned SATURAR     = 0,
    parameter  int unsigned LIMITE      = 40,
    parameter  int unsigned UMBRAL      = 4,
    localparam int unsigned ANCHO_TOTAL = f_ancho_total(N_BAT, ANCHO),
    localparam int unsigned ANCHO_CNT   = f_ancho_cnt(N_BAT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_BAT*ANCHO-1:0] cargas,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ANCHO_TOTAL-1:0] carga_total,
    output logic                   saturado,
    output logic [ANCHO_CNT-1:0]   bajas
);

    localparam int unsigned ANCHO_IDX = $clog2(N_BAT);

    estado_t                r_estado;
    estado_t                w_estado_nxt;
    logic [N_BAT*ANCHO-1:0] r_sombra;
    logic [ANCHO_TOTAL-1:0] r_acc;
    logic [ANCHO_IDX-1:0]   r_idx;
    logic [ANCHO_CNT-1:0]   r_cnt;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [ANCHO_TOTAL-1:0] r_total;
    logic                   r_saturado;
    logic [ANCHO_CNT-1:0]   r_bajas;

    logic                   w_in_ready_nxt;
    logic                   w_out_valid_nxt;
    logic [ANCHO-1:0]       w_carga_sel;
    logic                   w_baja;
    logic [ANCHO_TOTAL-1:0] w_suma;
    logic                   w_cout;
    logic [ANCHO_CNT-1:0]   w_cnt_nxt;
    logic                   w_ultimo;
    logic                   w_satura;

    // Select the battery addressed by the index from the shadow copy
    always_comb begin
        w_carga_sel = '0;
        for (int i = 0; i < int'(N_BAT); i++) begin
            if (r_idx == ANCHO_IDX'(i)) begin
                w_carga_sel = r_sombra[i*ANCHO +: ANCHO];
            end
        end
    end

    assign w_baja    = (32'(w_carga_sel) < UMBRAL);
    assign w_cnt_nxt = r_cnt + ANCHO_CNT'(w_baja);
    assign w_ultimo  = (r_idx == ANCHO_IDX'(N_BAT - 1));

    sumador_ripple_n #(
        .ANCHO (ANCHO_TOTAL)
    ) u_sumador (
        .i_a    (r_acc),
        .i_b    (ANCHO_TOTAL'(w_carga_sel)),
        .o_suma (w_suma),
        .o_cout (w_cout)
    );

    // Clamp decision on the full adder result including its carry-out
    assign w_satura = (SATURAR != 0) &&
                      ({w_cout, w_suma} > (ANCHO_TOTAL + 1)'(LIMITE));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= IDLE;
        end else begin
            r_estado <= w_estado_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_estado_nxt = r_estado;
        case (r_estado)
            IDLE:    if (in_valid)  w_estado_nxt = ACUM;
            ACUM:    if (w_ultimo)  w_estado_nxt = DONE;
            DONE:    if (out_ready) w_estado_nxt = IDLE;
            default: w_estado_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the upcoming state, then registered
    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        case (w_estado_nxt)
            IDLE:    w_in_ready_nxt  = 1'b1;
            DONE:    w_out_valid_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Datapath: capture on accept, accumulate in ACUM, latch results on the last battery
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sombra   <= '0;
            r_acc      <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_total    <= '0;
            r_saturado <= 1'b0;
            r_bajas    <= '0;
        end else if ((r_estado == IDLE) && in_valid) begin
            r_sombra <= cargas;
            r_acc    <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
        end else if (r_estado == ACUM) begin
            r_acc <= w_suma;
            r_idx <= r_idx + ANCHO_IDX'(1);
            r_cnt <= w_cnt_nxt;
            if (w_ultimo) begin
                r_total    <= w_satura ? ANCHO_TOTAL'(LIMITE) : w_suma;
                r_saturado <= w_satura;
                r_bajas    <= w_cnt_nxt;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign carga_total = r_total;
    assign saturado    = r_saturado;
    assign bajas       = r_bajas;

endmodule

// File: tb/tb_suma_carga_multi.sv
// Directed bench for suma_carga_multi: a default instance and a clamping
// instance (SATURAR=1, LIMITE=40) share the same stimulus.
module tb_suma_carga_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] cargas;

    logic        in_ready,  out_valid,  saturado;
    logic [5:0]  carga_total;
    logic [2:0]  bajas;
    logic        s_in_ready, s_out_valid, s_saturado;
    logic [5:0]  s_carga_total;
    logic [2:0]  s_bajas;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    suma_carga_multi u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cargas      (cargas),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .carga_total (carga_total),
        .saturado    (saturado),
        .bajas       (bajas)
    );

    suma_carga_multi #(
        .SATURAR (1),
        .LIMITE  (40)
    ) u_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (s_in_ready),
        .cargas      (cargas),
        .out_valid   (s_out_valid),
        .out_ready   (out_ready),
        .carga_total (s_carga_total),
        .saturado    (s_saturado),
        .bajas       (s_bajas)
    );

    typedef struct {
        logic [15:0] c;
        int unsigned tot;
        int unsigned baj;
        int unsigned tot_s;
        logic        sat_s;
    } vec_t;

    vec_t tabla [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present c in IDLE and return #1 after the accepting edge
    task automatic accept(input logic [15:0] c);
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        cargas   = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cargas   = ~c;
        check("busy_after_accept", 32'(in_ready), 32'd0);
    endtask

    // Count edges until out_valid rises, bounded
    task automatic wait_out(input int exp_lat);
        int n;
        n = 0;
        while (n < 50) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
        end
        check("latency", 32'(n), 32'(exp_lat));
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        tabla[0] = '{16'h9753, 24, 1, 24, 1'b0};
        tabla[1] = '{16'hFFFF, 60, 0, 40, 1'b1};
        tabla[2] = '{16'h0000,  0, 4,  0, 1'b0};
        tabla[3] = '{16'hAAAA, 40, 0, 40, 1'b0};
        tabla[4] = '{16'hBAAA, 41, 0, 40, 1'b1};
        tabla[5] = '{16'h1234, 10, 3, 10, 1'b0};
        tabla[6] = '{16'h4F00, 19, 2, 19, 1'b0};
        tabla[7] = '{16'hC3B8, 34, 1, 34, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cargas    = '0;
        #12;
        check("rst_in_ready",  32'(in_ready),    32'd1);
        check("rst_out_valid", 32'(out_valid),   32'd0);
        check("rst_total",     32'(carga_total), 32'd0);
        check("rst_saturado",  32'(saturado),    32'd0);
        check("rst_bajas",     32'(bajas),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven transactions
        for (int i = 0; i < 8; i++) begin
            accept(tabla[i].c);
            wait_out(4);
            check("total",       32'(carga_total),   tabla[i].tot);
            check("bajas",       32'(bajas),         tabla[i].baj);
            check("saturado",    32'(saturado),      32'd0);
            check("sat_valid",   32'(s_out_valid),   32'd1);
            check("sat_total",   32'(s_carga_total), tabla[i].tot_s);
            check("sat_flag",    32'(s_saturado),    32'(tabla[i].sat_s));
            check("sat_bajas",   32'(s_bajas),       tabla[i].baj);
            release_out();
            check("sat_ready",   32'(s_in_ready),    32'd1);
        end

        // Backpressure and ignored handshakes while busy
        accept(16'h9753);
        @(negedge clk);
        in_valid  = 1'b1;
        cargas    = 16'hFFFF;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wait_out(3);
        check("bp_total", 32'(carga_total), 32'd24);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            cargas   = 16'(k * 16'h1111);
            @(posedge clk);
            #1;
            check("bp_valid_hold", 32'(out_valid),   32'd1);
            check("bp_total_hold", 32'(carga_total), 32'd24);
            check("bp_bajas_hold", 32'(bajas),       32'd1);
            check("bp_not_ready",  32'(in_ready),    32'd0);
        end
        in_valid = 1'b0;
        release_out();
        check("bp_total_kept", 32'(carga_total), 32'd24);
        accept(16'h1234);
        wait_out(4);
        check("bp_next_total", 32'(carga_total), 32'd10);
        check("bp_next_bajas", 32'(bajas),       32'd3);
        release_out();

        // Asynchronous reset in the middle of accumulation
        accept(16'hFFFF);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  32'(in_ready),      32'd1);
        check("mid_rst_out_valid", 32'(out_valid),     32'd0);
        check("mid_rst_total",     32'(carga_total),   32'd0);
        check("mid_rst_bajas",     32'(bajas),         32'd0);
        check("mid_rst_sat_total", 32'(s_carga_total), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("no_valid_after_rst", 32'(seen), 32'd0);
        accept(16'h1234);
        wait_out(4);
        check("post_rst_total", 32'(carga_total), 32'd10);
        release_out();

        // Back-to-back: new data held during DONE is taken only after release
        accept(16'h9753);
        wait_out(4);
        check("b2b_first_total", 32'(carga_total), 32'd24);
        @(negedge clk);
        in_valid = 1'b1;
        cargas   = 16'h1234;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("b2b_not_ready", 32'(in_ready),    32'd0);
            check("b2b_hold",      32'(carga_total), 32'd24);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("b2b_valid_drop", 32'(out_valid), 32'd0);
        check("b2b_ready_idle", 32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_second_accept", 32'(in_ready), 32'd0);
        wait_out(4);
        check("b2b_second_total", 32'(carga_total), 32'd10);
        check("b2b_second_bajas", 32'(bajas),       32'd3);
        release_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
